// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-subtractor stage plus a borrow flip-flop does all the arithmetic.

module fs_hs (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_sub,
  output logic o_bor
);
  assign o_sub = i_a ^ i_b ^ i_bin;
  assign o_bor = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module serial_sub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = N - 1;

  // Handshake: start is a request sampled on the rising edge and accepted
  // only when busy=0 (IDLE or DONE); done is a one-cycle pulse marking
  // diff/bout valid, and they stay held until the next completion.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_a_sr;
  logic [N-1:0]    r_b_sr;
  logic [RW-1:0]   r_res;
  logic            r_bor;
  logic [CW-1:0]   r_cnt;
  logic            w_sub;
  logic            w_bor;
  logic            w_accept;
  logic            w_last;

  fs_hs u_fs (
    .i_a   (r_a_sr[0]),
    .i_b   (r_b_sr[0]),
    .i_bin (r_bor),
    .o_sub (w_sub),
    .o_bor (w_bor)
  );

  assign w_accept = start && (r_state != S_SHIFT);
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Only the low N-1 result bits are buffered; the final bit goes straight to diff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_res  <= '0;
      r_bor  <= 1'b0;
      r_cnt  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_bor  <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_res  <= (r_res >> 1) | (RW'(w_sub) << (RW - 1));
      r_bor  <= w_bor;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        diff <= {w_sub, r_res};
        bout <= w_bor;
      end
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at N=8 and N=16; drivers push expected
// {bout,diff} into queues and per-instance monitors pop them on done.

module tb_serial_sub;
  localparam int N  = 8;
  localparam int N2 = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          busy, done, bout;
  logic [N-1:0]  diff;

  logic          start2 = 1'b0;
  logic [N2-1:0] a2 = '0;
  logic [N2-1:0] b2 = '0;
  logic          busy2, done2, bout2;
  logic [N2-1:0] diff2;

  logic [N:0]    exp_q[$];
  logic [N2:0]   exp2_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;

  serial_sub #(.N(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_sub #(.N(N2)) u_dut16 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitors: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done8", 32'(done), 32'd0);
      end else begin
        logic [N:0] e;
        e = exp_q.pop_front();
        check("diff8", 32'(diff), 32'(e[N-1:0]));
        check("bout8", 32'(bout), 32'(e[N]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (exp2_q.size() == 0) begin
        check("spurious_done16", 32'(done2), 32'd0);
      end else begin
        logic [N2:0] e;
        e = exp2_q.pop_front();
        check("diff16", 32'(diff2), 32'(e[N2-1:0]));
        check("bout16", 32'(bout2), 32'(e[N2]));
      end
    end
  end

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  // One pulsed start; checks busy on each of the N shift cycles and done after them.
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic [N-1:0] ed, input logic eb);
    exp_q.push_back({eb, ed});
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; a = $urandom_range(255, 0); b = $urandom_range(255, 0);
    for (int i = 0; i < N; i++) begin
      check("busy_shift", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("done_latency", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(8'd200, 8'd55, 8'h91, 1'b0);
    run_op(8'd55, 8'd200, 8'h6F, 1'b1);
    run_op(8'd0, 8'd1, 8'hFF, 1'b1);
    run_op(8'hA5, 8'hA5, 8'h00, 1'b0);

    // start pulses while busy must be ignored
    exp_q.push_back({1'b0, 8'd7});
    @(negedge clk);
    start = 1'b1; a = 8'd10; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'd99; b = 8'd1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    @(negedge clk);
    check("ignore_idle_busy", 32'(busy), 32'd0);
    check("ignore_idle_done", 32'(done), 32'd0);

    // start held high: done every N+1 cycles, diff held between pulses
    repeat (3) exp_q.push_back({1'b0, 8'hE1});
    @(negedge clk);
    start = 1'b1; a = 8'hF0; b = 8'h0F;
    @(negedge clk);
    check("hold_prev_diff", 32'(diff), 32'd7);
    wait_done("stream0");
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        if (cnt == 4) check("stream_hold_diff", 32'(diff), 32'hE1);
      end while (!done && cnt < 40);
      check("stream_period", 32'(cnt), 32'(N + 1));
    end
    start = 1'b0;
    @(negedge clk);
    check("stream_stop", 32'(busy), 32'd0);

    // asynchronous reset mid-operation discards it
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (N + 2) @(negedge clk);
    check("arst_no_done_busy", 32'(busy), 32'd0);
    run_op(8'd7, 8'd9, 8'hFE, 1'b1);

    // N=16 instance
    exp2_q.push_back({1'b1, 16'h0001});
    @(negedge clk);
    start2 = 1'b1; a2 = 16'h0000; b2 = 16'hFFFF;
    @(negedge clk);
    start2 = 1'b0;
    cnt = 0;
    while (busy2 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("n16_shift_cycles", 32'(cnt), 32'(N2));
    check("n16_done", 32'(done2), 32'd1);
    repeat (2) @(negedge clk);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp2_q_drained", 32'(exp2_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
